// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // Execute-stage operand source select.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the 5-stage pipeline datapath (master) and the hazard unit (slave).
// No valid/ready pairs here: every signal is level-sampled each cycle, the
// pipeline presents stage register fields and the hazard unit answers in the same cycle.
interface hazard_ctrl_if #(
  parameter int REG_AW    = 5,
  parameter int CNT_WIDTH = 32
);
  logic [REG_AW-1:0]    Rs1D;
  logic [REG_AW-1:0]    Rs2D;
  logic [REG_AW-1:0]    Rs1E;
  logic [REG_AW-1:0]    Rs2E;
  logic [REG_AW-1:0]    RdE;
  logic [REG_AW-1:0]    RdM;
  logic [REG_AW-1:0]    RdW;
  logic                 MemReadE;
  logic                 RegWriteM;
  logic                 RegWriteW;
  logic                 PCSrcE;
  logic                 MemReqM;
  logic                 MemReadyM;

  logic                 StallF;
  logic                 StallD;
  logic                 StallE;
  logic                 StallM;
  logic                 FlushD;
  logic                 FlushE;
  logic                 FlushW;
  logic [1:0]           ForwardAE;
  logic [1:0]           ForwardBE;
  logic                 MemTimeout;
  logic [CNT_WIDTH-1:0] StallCycles;
  logic [CNT_WIDTH-1:0] FlushEvents;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushEvents
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushEvents
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one Execute operand; Memory-stage result wins over Writeback.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_en,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_write_m,
  input  logic              i_reg_write_w,
  output logic [1:0]        o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value.
  assign w_hit_m = i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs);
  assign w_hit_w = i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_en) begin
      if (w_hit_m) begin
        o_fwd = FWD_M;
      end else if (w_hit_w) begin
        o_fwd = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W core: warm-up hold, load-use stall, branch flush,
// operand forwarding, data-memory freeze with sticky timeout, saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int WARMUP_CYCLES = 2,
  parameter int MEM_TIMEOUT   = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz,
  output hz_state_e     o_state
);

  localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(MEM_TIMEOUT - 1);

  hz_state_e            r_state;
  logic [WU_W-1:0]      r_warm_cnt;
  logic [WT_W-1:0]      r_wait_cnt;
  logic                 r_mem_timeout;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic       w_active;
  logic       w_freeze;
  logic       w_load_stall;
  logic       w_branch;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_w;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_active     = (r_state != WARMUP);
  assign w_freeze     = w_active && hz.MemReqM && !hz.MemReadyM;
  assign w_load_stall = hz.MemReadE && (hz.RdE != '0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign w_branch     = w_active && !w_freeze && hz.PCSrcE;

  // Priority: warm-up hold, then memory freeze, then taken branch, then load-use.
  // A frozen E stage keeps its branch/load, so they get evaluated again on release.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (!w_active) begin
      w_stall_f = 1'b1;
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_freeze) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_load_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_en          (w_active),
    .i_rs          (hz.Rs1E),
    .i_rd_m        (hz.RdM),
    .i_rd_w        (hz.RdW),
    .i_reg_write_m (hz.RegWriteM),
    .i_reg_write_w (hz.RegWriteW),
    .o_fwd         (w_fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_en          (w_active),
    .i_rs          (hz.Rs2E),
    .i_rd_m        (hz.RdM),
    .i_rd_w        (hz.RdW),
    .i_reg_write_m (hz.RegWriteM),
    .i_reg_write_w (hz.RegWriteW),
    .o_fwd         (w_fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WARMUP;
      r_warm_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      case (r_state)
        WARMUP: begin
          if (r_warm_cnt == WU_LAST) begin
            r_state <= RUN;
          end else begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_freeze) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!w_freeze) begin
            r_state <= RUN;
          end else begin
            if (r_wait_cnt != '1) begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            // Sticky: only reset clears it, and it never alters the freeze itself.
            if (r_wait_cnt >= WT_LAST) begin
              r_mem_timeout <= 1'b1;
            end
          end
        end
        default: r_state <= WARMUP;
      endcase

      if (w_active && w_stall_f && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_branch && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign hz.StallF      = w_stall_f;
  assign hz.StallD      = w_stall_d;
  assign hz.StallE      = w_stall_e;
  assign hz.StallM      = w_stall_m;
  assign hz.FlushD      = w_flush_d;
  assign hz.FlushE      = w_flush_e;
  assign hz.FlushW      = w_flush_w;
  assign hz.ForwardAE   = w_fwd_a;
  assign hz.ForwardBE   = w_fwd_b;
  assign hz.MemTimeout  = r_mem_timeout;
  assign hz.StallCycles = r_stall_cnt;
  assign hz.FlushEvents = r_flush_cnt;
  assign o_state        = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table in RUN, random forwarding, freeze/timeout/saturation/reset sequences.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_AW = 5;
  localparam int WU     = 2;
  localparam int MT     = 4;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  typedef struct {
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        memreade, regwm, regww, pcsrc;
    logic [10:0] exp;
  } vec_t;

  logic      clk;
  logic      rst_n;
  hz_state_e dbg_state;

  hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_WIDTH(CW)) hz ();

  hazard_ctrl #(
    .REG_AW(REG_AW), .WARMUP_CYCLES(WU), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hz      (hz),
    .o_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_stall = 0;
  int          exp_flush = 0;
  logic [10:0] exp_q[$];
  vec_t        vecs[13];

  function automatic logic [10:0] mk(input logic sf, sd, se, sm, fd, fe, fw,
                                     input logic [1:0] fa, fb);
    return {sf, sd, se, sm, fd, fe, fw, fa, fb};
  endfunction

  function automatic vec_t mkv(input int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                               input logic memreade, regwm, regww, pcsrc,
                               input logic [10:0] e);
    vec_t v;
    v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
    v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
    v.memreade = memreade; v.regwm = regwm; v.regww = regww; v.pcsrc = pcsrc;
    v.exp = e;
    return v;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, rdm, rdw, input logic wm, ww);
    if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] out_bits();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
            hz.FlushW, hz.ForwardAE, hz.ForwardBE};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.MemReadE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
    hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
    hz.MemReadE = v.memreade; hz.RegWriteM = v.regwm; hz.RegWriteW = v.regww;
    hz.PCSrcE = v.pcsrc; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  // scoreboard: push expectation, compare at the negedge, then advance past the next posedge
  task automatic step(input string nm, input logic [10:0] e, input logic counted_flush);
    logic [10:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    check(nm, 32'(out_bits()), 32'(want));
    if (want[10] && exp_stall < CMAX) exp_stall++;
    if (counted_flush && exp_flush < CMAX) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string nm);
    check({nm, "_stall_cnt"}, 32'(hz.StallCycles), 32'(exp_stall));
    check({nm, "_flush_cnt"}, 32'(hz.FlushEvents), 32'(exp_flush));
  endtask

  // Expects rst_n already low; checks reset values, releases, checks warm-up, ends in RUN.
  task automatic reset_and_warmup(input string nm);
    #1;
    check({nm, "_rst_out"}, 32'(out_bits()), 32'(mk(1, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00)));
    check({nm, "_rst_state"}, 32'(dbg_state), 32'(WARMUP));
    check({nm, "_rst_timeout"}, 32'(hz.MemTimeout), 32'd0);
    check({nm, "_rst_stall_cnt"}, 32'(hz.StallCycles), 32'd0);
    check({nm, "_rst_flush_cnt"}, 32'(hz.FlushEvents), 32'd0);
    clear_inputs();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd3; hz.Rs1E = 5'd3;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < WU; c++) begin
      @(negedge clk);
      check({nm, "_warm_out"}, 32'(out_bits()), 32'(mk(1, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00)));
    end
    @(posedge clk);
    #1;
    check({nm, "_run_state"}, 32'(dbg_state), 32'(RUN));
    check({nm, "_run_out"}, 32'(out_bits()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00)));
    check({nm, "_warm_stall_cnt"}, 32'(hz.StallCycles), 32'd0);
    clear_inputs();
    exp_stall = 0;
    exp_flush = 0;
  endtask

  initial begin
    vec_t        rv;
    logic [10:0] frz;
    frz = mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00);

    //            rs1d rs2d rs1e rs2e rde rdm rdw  mre wm ww pc
    vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,2'b00,2'b00));
    vecs[1]  = mkv(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, mk(0,0,0,0,0,0,0,2'b10,2'b00));
    vecs[2]  = mkv(0, 0, 5, 0, 0, 0, 5, 0, 1, 1, 0, mk(0,0,0,0,0,0,0,2'b01,2'b00));
    vecs[3]  = mkv(0, 0, 3, 3, 0, 3, 0, 0, 1, 0, 0, mk(0,0,0,0,0,0,0,2'b10,2'b10));
    vecs[4]  = mkv(0, 0, 1, 9, 0, 9, 9, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,2'b00,2'b01));
    vecs[5]  = mkv(0, 0, 9, 0, 0, 0, 9, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,2'b00,2'b00));
    vecs[6]  = mkv(1, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, mk(1,1,0,0,0,1,0,2'b00,2'b00));
    vecs[7]  = mkv(1, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, mk(0,0,0,0,1,1,0,2'b00,2'b00));
    vecs[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,2'b00,2'b00));
    vecs[9]  = mkv(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,2'b00,2'b00));
    vecs[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,1,1,0,2'b00,2'b00));
    vecs[11] = mkv(4, 0, 4, 0, 4, 4, 0, 1, 1, 0, 0, mk(1,1,0,0,0,1,0,2'b10,2'b00));
    vecs[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, mk(0,0,0,0,0,0,0,2'b00,2'b00));

    rst_n = 1'b0;
    clear_inputs();
    reset_and_warmup("boot");

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      step($sformatf("vec%0d", i), vecs[i].exp, vecs[i].pcsrc);
    end
    check_counters("table");

    for (int i = 0; i < 8; i++) begin
      rv = mkv(0, 0, $urandom_range(0, 3), $urandom_range(0, 3), 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
      rv.exp = mk(0, 0, 0, 0, 0, 0, 0,
                  fwd_ref(rv.rs1e, rv.rdm, rv.rdw, rv.regwm, rv.regww),
                  fwd_ref(rv.rs2e, rv.rdm, rv.rdw, rv.regwm, rv.regww));
      apply(rv);
      step($sformatf("rnd_fwd%0d", i), rv.exp, 1'b0);
    end

    // three frozen cycles with a branch pending, then release
    clear_inputs();
    hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1; hz.MemReadE = 1'b1; hz.RdE = 5'd2; hz.Rs1D = 5'd2;
    for (int k = 0; k < 3; k++) begin
      step($sformatf("freeze%0d", k), frz, 1'b0);
      check("freeze_state", 32'(dbg_state), 32'(MEM_WAIT));
    end
    hz.MemReadyM = 1'b1;
    step("release_branch", mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00), 1'b1);
    check("release_state", 32'(dbg_state), 32'(RUN));
    check("release_timeout", 32'(hz.MemTimeout), 32'd0);
    check_counters("freeze");

    // timeout: RUN cycle plus four MEM_WAIT cycles
    clear_inputs();
    hz.MemReqM = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step($sformatf("to_freeze%0d", k), frz, 1'b0);
      check($sformatf("timeout_after%0d", k), 32'(hz.MemTimeout), (k == 4) ? 32'd1 : 32'd0);
    end
    hz.MemReadyM = 1'b1;
    step("to_release", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), 1'b0);
    check("timeout_sticky", 32'(hz.MemTimeout), 32'd1);
    hz.MemReqM = 1'b0;
    step("to_idle", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), 1'b0);
    check("timeout_sticky2", 32'(hz.MemTimeout), 32'd1);

    // saturate the stall counter with a long freeze
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step($sformatf("sat_freeze%0d", k), frz, 1'b0);
    end
    check("sat_stall_cnt", 32'(hz.StallCycles), 32'(CMAX));
    check_counters("sat");
    check("sat_state", 32'(dbg_state), 32'(MEM_WAIT));

    // asynchronous reset in the middle of a MEM_WAIT cycle
    #3 rst_n = 1'b0;
    reset_and_warmup("midwait");
    step("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), 1'b0);
    check_counters("post_reset");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got=%0d entries expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W).
- Sequences stalls, flushes and operand forwarding around the decode/extend and execute datapath.
- Holds a post-reset warm-up window and freezes the pipeline while data memory is not ready, with timeout detection.
- Keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- WARMUP_CYCLES, 2, cycles the front end is held after reset release (>=1).
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles before MemTimeout is flagged.
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  REG_AW  source registers in Decode
- Rs1E, Rs2E, RdE  in  REG_AW  source/dest registers in Execute
- RdM, RdW  in  REG_AW  dest register in Memory/Writeback
- MemReadE  in  1  Execute holds a load
- RegWriteM, RegWriteW  in  1  register write enables in M/W
- PCSrcE  in  1  taken branch or jump resolved in Execute
- MemReqM  in  1  data memory access in Memory
- MemReadyM  in  1  data memory completes this cycle
- StallF, StallD, StallE, StallM  out  1  hold the stage register
- FlushD, FlushE, FlushW  out  1  bubble the stage register
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- MemTimeout  out  1  sticky memory-timeout flag
- StallCycles, FlushEvents  out  CNT_WIDTH  performance counters

Behaviour:
- Async reset (rst_n=0):
  - state=WARMUP; warm-up/wait counters=0; MemTimeout=0; both perf counters=0.
  - Outputs during reset: StallF=1, FlushD=1, FlushE=1; all others 0.
- States: WARMUP, RUN, MEM_WAIT. Registered state. Stall/flush/forward outputs are combinational from state and inputs (Mealy).
- WARMUP:
  - StallF=1, FlushD=1, FlushE=1; forwarding 00.
  - Counter increments each cycle; after WARMUP_CYCLES cycles -> RUN.
  - Inputs are ignored.
- Forwarding, active in RUN and MEM_WAIT, per operand X in {1,2}:
  - 10 if RegWriteM && RdM!=0 && RdM==RsXE.
  - else 01 if RegWriteW && RdW!=0 && RdW==RsXE.
  - else 00.
  - M has priority over W.
- Load-use (RUN only): LoadStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) -> StallF=1, StallD=1, FlushE=1.
- Control hazard (RUN only): PCSrcE=1 -> FlushD=1, FlushE=1, StallF=0, StallD=0. This overrides LoadStall.
- Memory wait:
  - Freeze = MemReqM && !MemReadyM, in RUN or MEM_WAIT.
  - Freeze outputs: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Freeze overrides PCSrcE and LoadStall; these re-evaluate on release because E is held.
  - RUN with Freeze -> MEM_WAIT, wait counter cleared.
  - MEM_WAIT with MemReadyM=1 (or MemReqM=0) -> RUN. That cycle already uses RUN output rules.
- Timeout:
  - Wait counter saturates.
  - When it reaches MEM_TIMEOUT-1 while still in MEM_WAIT, MemTimeout is set the next edge and stays set until reset.
  - The freeze continues; MemTimeout has no effect on control.
- Performance counters, saturating at all-ones, not counted in WARMUP:
  - StallCycles +1 each cycle StallF=1.
  - FlushEvents +1 each cycle PCSrcE causes a flush (i.e. not frozen).
- Reset mid-MEM_WAIT: immediate return to WARMUP reset values.

Decomposition:
- hazard_pkg:
  - state enum {WARMUP, RUN, MEM_WAIT}.
  - forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- Sub-module fwd_sel (combinational, one operand), instantiated twice for A and B.

Test Plan:
- Reset, release rst_n -> StallF=1, FlushD=1, FlushE=1 for 2 cycles, then RUN with all outputs 0 and counters 0.
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00; RdM=0 -> ForwardAE=01.
- MemReadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle, StallCycles=1; add PCSrcE=1 same cycle -> StallF=0, FlushD=FlushE=1, FlushEvents=1.
- MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> freeze outputs for 3 cycles, PCSrcE=1 ignored meanwhile, StallCycles +3, RUN thereafter.
- MEM_TIMEOUT=4, MemReadyM held 0 -> MemTimeout=1 after 4 wait cycles and stays 1 after MemReadyM=1; cleared only by rst_n=0.
- rst_n asserted mid-MEM_WAIT -> all outputs/counters at reset values immediately; StallCycles preset near all-ones saturates, no wrap.
